q_8_34b_datapath: RTL and testbench



---
 rtl/q_8_34b_pkg.sv | 10 +
 rtl/q_8_34b_shift_reg.sv | 27 ++
 rtl/q_8_34b_datapath.sv | 34 +++
 tb/tb_q_8_34b_datapath.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/q_8_34b_pkg.sv
// q_8_34b_pkg: shared constants and command bundle for the q_8_34b ones counter
package q_8_34b_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W = $clog2(DATA_W + 1);
  typedef struct packed {
    logic load_regs;
    logic incr_r2;
    logic shift;
  } cmd_t;
endpackage

// File: rtl/q_8_34b_shift_reg.sv
// q_8_34b_shift_reg: operand register R1 with shifted-out bit E and zero detect
module q_8_34b_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data_in,
  output logic              e,
  output logic              zero
);
  logic [DATA_W-1:0] r1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
      e  <= 1'b0;
    end else if (load) begin
      r1 <= data_in;
      e  <= 1'b0;
    end else if (shift) begin
      r1 <= {r1[DATA_W-2:0], 1'b0};
      e  <= r1[DATA_W-1];
    end
  end
  assign zero = (r1 == '0);
endmodule

// File: rtl/q_8_34b_datapath.sv
// q_8_34b_datapath: executes load/incr/shift commands and reports zero and E
module q_8_34b_datapath
  import q_8_34b_pkg::*;
#(
  parameter int DATA_W = q_8_34b_pkg::DATA_W,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_regs,
  input  logic              incr_r2,
  input  logic              shift,
  input  logic [DATA_W-1:0] data_in,
  output logic              zero,
  output logic              E,
  output logic [CNT_W-1:0]  count
);
  cmd_t cmd;
  assign cmd = '{load_regs: load_regs, incr_r2: incr_r2, shift: shift};
  q_8_34b_shift_reg #(.DATA_W(DATA_W)) u_sr (
    .clk(clk),
    .rst(rst),
    .load(cmd.load_regs),
    .shift(cmd.shift && !cmd.load_regs),
    .data_in(data_in),
    .e(E),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (cmd.load_regs) count <= '1;
    else if (cmd.incr_r2) count <= count + CNT_W'(1);
  end
endmodule

// File: tb/tb_q_8_34b_datapath.sv
// tb_q_8_34b_datapath: randomized and directed checks against a behavioural model
module tb_q_8_34b_datapath;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_regs = 1'b0;
  logic incr_r2 = 1'b0;
  logic shift = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic zero;
  logic E;
  logic [3:0] count;
  int errors = 0;
  int checks = 0;
  logic [7:0] m_r1 = 8'h00;
  logic [3:0] m_r2 = 4'h0;
  logic m_e = 1'b0;

  q_8_34b_datapath dut (
    .clk(clk),
    .rst(rst),
    .load_regs(load_regs),
    .incr_r2(incr_r2),
    .shift(shift),
    .data_in(data_in),
    .zero(zero),
    .E(E),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic ld, input logic inc, input logic sh, input logic [7:0] din);
    rst = r;
    load_regs = ld;
    incr_r2 = inc;
    shift = sh;
    data_in = din;
    @(posedge clk);
    #1;
    if (r) begin
      m_r1 = 0;
      m_r2 = 0;
      m_e = 0;
    end else if (ld) begin
      m_r1 = din;
      m_r2 = 4'hF;
      m_e = 0;
    end else begin
      if (sh) begin
        m_e = m_r1[7];
        m_r1 = m_r1 << 1;
      end
      if (inc) m_r2 = m_r2 + 1;
    end
    rst = 0;
    load_regs = 0;
    incr_r2 = 0;
    shift = 0;
  endtask

  task automatic test_reset;
    drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    checks++;
    if (count !== 4'h0 || E !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset: count=%h E=%b zero=%b required count=0 E=0 zero=1", count, E, zero);
    end
    drive(1, 1, 0, 0, 8'hFF);
    drive(1, 1, 1, 1, 8'hFF);
    checks++;
    if (count !== 4'h0 || E !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_over_load: count=%h E=%b zero=%b required count=0 E=0 zero=1", count, E, zero);
    end
  endtask

  task automatic test_load;
    logic [7:0] got;
    drive(0, 1, 0, 0, 8'hA5);
    checks++;
    if (count !== 4'hF || E !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL load: count=%h E=%b zero=%b required count=f E=0 zero=0", count, E, zero);
    end
    drive(0, 0, 1, 0, 8'h00);
    checks++;
    if (count !== 4'h0) begin
      errors++;
      $display("FAIL load_wrap: count=%h required 0", count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      got[7-i] = E;
    end
    checks++;
    if (got !== 8'hA5 || zero !== 1'b1) begin
      errors++;
      $display("FAIL load_operand: shifted out %h zero=%b required a5 zero=1", got, zero);
    end
  endtask

  task automatic test_shift;
    logic [7:0] pat;
    pat = 8'h81;
    drive(0, 1, 0, 0, pat);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      checks++;
      if (E !== pat[7-i] || zero !== (i == 7)) begin
        errors++;
        $display("FAIL shift%0d: E=%b zero=%b required E=%b zero=%b", i + 1, E, zero, pat[7-i], i == 7);
      end
    end
    drive(0, 0, 0, 1, 8'h00);
    checks++;
    if (E !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL shift_empty: E=%b zero=%b required E=0 zero=1", E, zero);
    end
  endtask

  task automatic test_simultaneous;
    drive(0, 1, 0, 0, 8'h80);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h00);
    checks++;
    if (E !== 1'b1 || zero !== 1'b1 || count !== 4'h3) begin
      errors++;
      $display("FAIL shift_incr: E=%b zero=%b count=%h required E=1 zero=1 count=3", E, zero, count);
    end
    drive(0, 1, 1, 1, 8'h0F);
    checks++;
    if (E !== 1'b0 || zero !== 1'b0 || count !== 4'hF) begin
      errors++;
      $display("FAIL load_wins: E=%b zero=%b count=%h required E=0 zero=0 count=f", E, zero, count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 8'h00);
      checks++;
      if (E !== (i >= 4)) begin
        errors++;
        $display("FAIL load_wins_bit%0d: E=%b required %b", i, E, i >= 4);
      end
    end
  endtask

  task automatic run_controller(input logic [7:0] din);
    bit inc_phase;
    bit done;
    int incs;
    inc_phase = 1;
    done = 0;
    incs = 0;
    drive(0, 1, 0, 0, din);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (inc_phase) begin
        drive(0, 0, 1, 0, 8'h00);
        incs++;
        inc_phase = 0;
      end else if (zero) begin
        done = 1;
      end else begin
        drive(0, 0, 0, 1, 8'h00);
        inc_phase = E;
      end
    end
    checks++;
    if (!done || count !== 4'($countones(din)) || incs != $countones(din) + 1) begin
      errors++;
      $display("FAIL controller_%h: done=%0d count=%0d incs=%0d required count=%0d incs=%0d",
               din, done, count, incs, $countones(din), $countones(din) + 1);
    end
  endtask

  task automatic test_controller;
    run_controller(8'hB6);
    run_controller(8'h00);
    run_controller(8'hFF);
    run_controller(8'($urandom));
  endtask

  task automatic test_reset_mid;
    drive(0, 1, 0, 0, 8'hF0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 1, 1, 8'h00);
    checks++;
    if (zero !== 1'b1 || E !== 1'b0 || count !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: zero=%b E=%b count=%h required zero=1 E=0 count=0", zero, E, count);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 8'($urandom));
    checks++;
    if (zero !== 1'b1 || E !== 1'b0 || count !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_hold: zero=%b E=%b count=%h required zero=1 E=0 count=0", zero, E, count);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom), 8'($urandom));
      checks++;
      if (count !== m_r2 || E !== m_e || zero !== (m_r1 == 0)) begin
        errors++;
        $display("FAIL random%0d: count=%h E=%b zero=%b required count=%h E=%b zero=%b",
                 i, count, E, zero, m_r2, m_e, m_r1 == 0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_shift;
    test_simultaneous;
    test_controller;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
